// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Works on operand magnitudes: radix-2 shift-add multiply or restoring divide over XLEN steps,
// then a single sign-correction cycle. A start/busy/valid handshake lets the hazard unit stall.
//
// Ports:
//   clk     in   1     clock, rising edge
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     op request, sampled only while busy=0 (IDLE or DONE)
//   funct3  in   3     RV32M funct3 selecting the operation
//   in_a    in   XLEN  rs1 (multiplicand / dividend)
//   in_b    in   XLEN  rs2 (multiplier / divisor)
//   busy    out  1     high while an op is iterating (CALC/FIX)
//   valid   out  1     one-cycle pulse when out holds a new result
//   out     out  XLEN  result register, held until the next valid
//
// Configuration macro: MULDIV_EARLY_EXIT_EN
//   When defined, div-by-zero, signed overflow and multiplies by zero finish at the start edge.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] out
);

   localparam int unsigned CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

   state_t          state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]      op;
   logic [XLEN-1:0] ma, mb;
   // mul: hi = running upper product, lo = multiplier shifting out / product low half
   // div: hi = partial remainder, lo = dividend shifting out / quotient shifting in
   logic [XLEN-1:0] hi, lo;
   logic            neg;

   // Operand decode
   logic            a_signed, b_signed, a_neg, b_neg, res_neg;
   logic [XLEN-1:0] mag_a, mag_b;

   always_comb begin
      a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
      b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
      a_neg    = a_signed & in_a[XLEN-1];
      b_neg    = b_signed & in_b[XLEN-1];
      mag_a    = a_neg ? -in_a : in_a;
      mag_b    = b_neg ? -in_b : in_b;
      // Remainder follows the dividend; a zero divisor must leave the quotient at all ones.
      if (funct3[2]) begin
         res_neg = funct3[1] ? a_neg : ((a_neg ^ b_neg) & (in_b != '0));
      end else begin
         res_neg = a_neg ^ b_neg;
      end
   end

   // One iteration step for each datapath
   logic [XLEN:0]   mul_sum, div_tmp, div_diff;
   logic            div_ge;
   logic [XLEN-1:0] mul_hi, mul_lo, div_hi, div_lo;

   always_comb begin
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, ma} : '0);
      mul_hi   = mul_sum[XLEN:1];
      mul_lo   = {mul_sum[0], lo[XLEN-1:1]};
      div_tmp  = {hi, lo[XLEN-1]};
      div_diff = div_tmp - {1'b0, mb};
      // The partial remainder stays below 2^XLEN, so the top bit is a pure borrow flag.
      div_ge   = ~div_diff[XLEN];
      div_hi   = div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0];
      div_lo   = {lo[XLEN-2:0], div_ge};
   end

   // Sign correction
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   div_val, fix_res;

   always_comb begin
      prod_s  = neg ? -{hi, lo} : {hi, lo};
      div_val = op[1] ? hi : lo;
      if (op[2]) begin
         fix_res = neg ? -div_val : div_val;
      end else if (op[1:0] == 2'b00) begin
         fix_res = prod_s[XLEN-1:0];
      end else begin
         fix_res = prod_s[2*XLEN-1:XLEN];
      end
   end

   // Early-exit detection
   logic            early_hit;
   logic [XLEN-1:0] early_res;

`ifdef MULDIV_EARLY_EXIT_EN
   always_comb begin
      early_hit = 1'b0;
      early_res = '0;
      if (funct3[2]) begin
         if (in_b == '0) begin
            early_hit = 1'b1;
            early_res = funct3[1] ? in_a : '1;
         end else if (!funct3[0] && in_a == MIN_NEG && in_b == '1) begin
            early_hit = 1'b1;
            early_res = funct3[1] ? '0 : MIN_NEG;
         end
      end else if (in_a == '0 || in_b == '0) begin
         early_hit = 1'b1;
      end
   end
`else
   assign early_hit = 1'b0;
   assign early_res = MIN_NEG & '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= StIdle;
         busy  <= 1'b0;
         valid <= 1'b0;
         out   <= '0;
         cnt   <= '0;
         op    <= '0;
         ma    <= '0;
         mb    <= '0;
         hi    <= '0;
         lo    <= '0;
         neg   <= 1'b0;
      end else begin
         case (state)
            StIdle, StDone: begin
               valid <= 1'b0;
               if (start) begin
                  op  <= funct3;
                  ma  <= mag_a;
                  mb  <= mag_b;
                  neg <= res_neg;
                  hi  <= '0;
                  lo  <= funct3[2] ? mag_a : mag_b;
                  cnt <= '0;
                  if (early_hit) begin
                     out   <= early_res;
                     valid <= 1'b1;
                     state <= StDone;
                  end else begin
                     busy  <= 1'b1;
                     state <= StCalc;
                  end
               end else begin
                  state <= StIdle;
               end
            end
            StCalc: begin
               hi  <= op[2] ? div_hi : mul_hi;
               lo  <= op[2] ? div_lo : mul_lo;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  state <= StFix;
               end
            end
            StFix: begin
               out   <= fix_res;
               busy  <= 1'b0;
               valid <= 1'b1;
               state <= StDone;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
